mesi_snoop_array: RTL

//  Parametrised snoop-side MESI controller for an entire direct-mapped cache.

---
 rtl/mesi_snoop_array.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mesi_snoop_array.sv
// Snoop-side MESI controller for a direct-mapped cache.
// One bus snoop at a time; M hits go through a write-back handshake.
module mesi_snoop_array #(
  parameter int LINES  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              snp_valid,
  output logic              snp_ready,
  input  logic [1:0]        snp_op,
  input  logic [ADDR_W-1:0] snp_addr,
  output logic              snp_done,
  output logic              snp_hit,
  output logic              snp_shared,
  output logic              snp_abort,
  output logic              snp_err,
  output logic              wb_req,
  output logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_ack,
  input  logic              loc_we,
  output logic              loc_ready,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [1:0]        loc_state,
  output logic [1:0]        loc_rd_state
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_RDX = 2'b10;
  localparam logic [1:0] OP_INV = 2'b11;

  typedef enum logic [1:0] {IDLE, LOOKUP, WB_WAIT} fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [1:0]        st_q  [LINES];
  logic [1:0]        st_d  [LINES];
  logic [TAG_W-1:0]  tag_q [LINES];
  logic [TAG_W-1:0]  tag_d [LINES];
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              hit_q, hit_d;
  logic              shared_q, shared_d;
  logic              abort_q, abort_d;
  logic              err_q, err_d;
  logic              wb_req_q, wb_req_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;

  logic [IDX_W-1:0]  s_idx, l_idx;
  logic [TAG_W-1:0]  s_tag, l_tag;
  logic [1:0]        lk_st;
  logic              lk_hit;

  assign s_idx  = addr_q[IDX_W-1:0];
  assign s_tag  = addr_q[ADDR_W-1:IDX_W];
  assign l_idx  = loc_addr[IDX_W-1:0];
  assign l_tag  = loc_addr[ADDR_W-1:IDX_W];
  assign lk_st  = st_q[s_idx];
  assign lk_hit = (lk_st != ST_I) && (tag_q[s_idx] == s_tag);

  assign snp_ready    = (fsm_q == IDLE);
  assign loc_ready    = !((fsm_q != IDLE) && (l_idx == s_idx));
  assign loc_rd_state = st_q[l_idx];
  assign snp_done     = done_q;
  assign snp_hit      = hit_q;
  assign snp_shared   = shared_q;
  assign snp_abort    = abort_q;
  assign snp_err      = err_q;
  assign wb_req       = wb_req_q;
  assign wb_addr      = wb_addr_q;

  always_comb begin
    st_d      = st_q;
    tag_d     = tag_q;
    fsm_d     = fsm_q;
    op_d      = op_q;
    addr_d    = addr_q;
    done_d    = 1'b0;
    hit_d     = 1'b0;
    shared_d  = 1'b0;
    abort_d   = 1'b0;
    err_d     = 1'b0;
    wb_req_d  = wb_req_q;
    wb_addr_d = wb_addr_q;
    // Never targets the snooped line: loc_ready blocks that index.
    if (loc_we && loc_ready) begin
      st_d[l_idx]  = loc_state;
      tag_d[l_idx] = l_tag;
    end
    unique case (fsm_q)
      IDLE: begin
        if (snp_valid && snp_op != 2'b00) begin
          op_d   = snp_op;
          addr_d = snp_addr;
          fsm_d  = LOOKUP;
        end
      end
      LOOKUP: begin
        fsm_d = IDLE;
        if (!lk_hit) begin
          done_d = 1'b1;
        end else if (lk_st == ST_M && op_q != OP_INV) begin
          abort_d   = 1'b1;
          wb_req_d  = 1'b1;
          wb_addr_d = addr_q;
          fsm_d     = WB_WAIT;
        end else begin
          done_d = 1'b1;
          hit_d  = 1'b1;
          if (op_q == OP_RD) begin
            st_d[s_idx] = ST_S;
            shared_d    = 1'b1;
          end else begin
            st_d[s_idx] = ST_I;
            err_d = (op_q == OP_INV) &&
                    (lk_st == ST_E || lk_st == ST_M);
          end
        end
      end
      WB_WAIT: begin
        abort_d = 1'b1;
        if (wb_ack) begin
          wb_req_d    = 1'b0;
          done_d      = 1'b1;
          hit_d       = 1'b1;
          shared_d    = (op_q == OP_RD);
          st_d[s_idx] = (op_q == OP_RD) ? ST_S : ST_I;
          fsm_d       = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      fsm_q     <= IDLE;
      op_q      <= 2'b00;
      addr_q    <= '0;
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
      shared_q  <= 1'b0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
      wb_req_q  <= 1'b0;
      wb_addr_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        st_q[i]  <= ST_I;
        tag_q[i] <= '0;
      end
    end else begin
      fsm_q     <= fsm_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
      hit_q     <= hit_d;
      shared_q  <= shared_d;
      abort_q   <= abort_d;
      err_q     <= err_d;
      wb_req_q  <= wb_req_d;
      wb_addr_q <= wb_addr_d;
      for (int i = 0; i < LINES; i++) begin
        st_q[i]  <= st_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end
endmodule
